// File: rtl/vc_sched_pkg.sv
// Shared types and constants for the vc_sched weighted round-robin scheduler.
// Holds the FSM encoding, the VC id constants, the default weights and a one-hot decode helper.
package vc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        STALL = 2'b10
    } state_t;

    localparam logic [1:0] VCHANNEL0 = 2'b00;
    localparam logic [1:0] VCHANNEL1 = 2'b01;
    localparam logic [1:0] VCHANNEL2 = 2'b10;
    localparam logic [1:0] VCHANNEL3 = 2'b11;

    localparam int NUM_VC = 4;

    localparam int DEF_WEIGHT0  = 3;
    localparam int DEF_WEIGHT1  = 2;
    localparam int DEF_WEIGHT2  = 2;
    localparam int DEF_WEIGHT3  = 1;
    localparam int DEF_WEIGHT_W = 3;

    // Encodes a one-hot pop vector into a VC id; an all-zero vector decodes to VCHANNEL0.
    function automatic logic [1:0] onehot_to_id(input logic [3:0] oh);
        logic [1:0] id;
        id = VCHANNEL0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (oh[i]) id = i[1:0];
        end
        return id;
    endfunction

endpackage

// File: rtl/vc_sched_rr_next_vc.sv
// Combinational round-robin search: returns the first non-empty VC at or after
// the start index, wrapping around modulo 4.
module rr_next_vc
    import vc_sched_pkg::*;
(
    input  logic [3:0] nonempty,
    input  logic [1:0] start,
    output logic [1:0] next_vc,
    output logic       any_valid
);

    logic [1:0] idx;

    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        next_vc   = start;
        any_valid = |nonempty;
        idx       = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            idx = start + i[1:0];
            if (nonempty[idx]) next_vc = idx;
        end
    end

endmodule

// File: rtl/vc_sched.sv
// Weighted round-robin pop scheduler for four VC FIFOs feeding one output FIFO.
// Optional per-VC grant counters are built when VC_SCHED_STATS_EN is defined.
module vc_sched
    import vc_sched_pkg::*;
#(
    parameter int WEIGHT0  = DEF_WEIGHT0,
    parameter int WEIGHT1  = DEF_WEIGHT1,
    parameter int WEIGHT2  = DEF_WEIGHT2,
    parameter int WEIGHT3  = DEF_WEIGHT3,
    parameter int WEIGHT_W = DEF_WEIGHT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       empty_vchannel0,
    input  logic       empty_vchannel1,
    input  logic       empty_vchannel2,
    input  logic       empty_vchannel3,
    input  logic       almost_full_out,
    output logic [3:0] pop_vchannel,
    output logic [1:0] sel_vchannel,
    output logic       push_out,
    output logic       idle,
    output logic [7:0] grant_cnt0,
    output logic [7:0] grant_cnt1,
    output logic [7:0] grant_cnt2,
    output logic [7:0] grant_cnt3
);

    state_t              state_q, state_d;
    logic [1:0]          cur_vc_q, cur_vc_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [3:0]          pop_q, pop_d;
    logic                push_q, push_d;
    logic [1:0]          sel_q, sel_d;

    logic [3:0] nonempty;
    logic [1:0] search_start;
    logic [1:0] nxt_vc;
    logic       any_valid;

    assign nonempty     = ~{empty_vchannel3, empty_vchannel2, empty_vchannel1, empty_vchannel0};
    assign search_start = cur_vc_q + 2'd1;

    rr_next_vc u_rr_next_vc (
        .nonempty  (nonempty),
        .start     (search_start),
        .next_vc   (nxt_vc),
        .any_valid (any_valid)
    );

    // Credit counts the pops still owed after the one issued on load, hence weight - 1.
    function automatic logic [WEIGHT_W-1:0] reload_credit(input logic [1:0] vc);
        logic [WEIGHT_W-1:0] w;
        case (vc)
            VCHANNEL0: w = WEIGHT_W'(WEIGHT0);
            VCHANNEL1: w = WEIGHT_W'(WEIGHT1);
            VCHANNEL2: w = WEIGHT_W'(WEIGHT2);
            default:   w = WEIGHT_W'(WEIGHT3);
        endcase
        return w - WEIGHT_W'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        cur_vc_d = cur_vc_q;
        credit_d = credit_q;
        pop_d    = '0;
        // The read pipeline runs regardless of enb or stall so an issued pop is never dropped.
        push_d   = |pop_q;
        sel_d    = (|pop_q) ? onehot_to_id(pop_q) : sel_q;

        if (enb) begin
            if (almost_full_out) begin
                state_d = STALL;
            end else if (state_q == IDLE || credit_q == '0 || !nonempty[cur_vc_q]) begin
                // Switch point: leftover credit is dropped and the next non-empty VC takes over.
                if (any_valid) begin
                    state_d  = SERVE;
                    cur_vc_d = nxt_vc;
                    credit_d = reload_credit(nxt_vc);
                    pop_d    = 4'b0001 << nxt_vc;
                end else begin
                    state_d  = IDLE;
                    credit_d = '0;
                end
            end else begin
                state_d  = SERVE;
                credit_d = credit_q - WEIGHT_W'(1);
                pop_d    = 4'b0001 << cur_vc_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_vc_q <= VCHANNEL3;
            credit_q <= '0;
            pop_q    <= '0;
            push_q   <= 1'b0;
            sel_q    <= VCHANNEL0;
        end else begin
            state_q  <= state_d;
            cur_vc_q <= cur_vc_d;
            credit_q <= credit_d;
            pop_q    <= pop_d;
            push_q   <= push_d;
            sel_q    <= sel_d;
        end
    end

    assign pop_vchannel = pop_q;
    assign push_out     = push_q;
    assign sel_vchannel = sel_q;
    assign idle         = (state_q == IDLE);

`ifdef VC_SCHED_STATS_EN
    logic [7:0] gcnt_q [NUM_VC];
    logic [7:0] gcnt_d [NUM_VC];

    // Counted when the pop is issued; saturates rather than wrapping.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (pop_d[i] && gcnt_q[i] != 8'hFF) gcnt_d[i] = gcnt_q[i] + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) gcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) gcnt_q[i] <= gcnt_d[i];
        end
    end

    assign grant_cnt0 = gcnt_q[0];
    assign grant_cnt1 = gcnt_q[1];
    assign grant_cnt2 = gcnt_q[2];
    assign grant_cnt3 = gcnt_q[3];
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
    assign grant_cnt2 = '0;
    assign grant_cnt3 = '0;
`endif

endmodule

// File: tb/tb_vc_sched.sv
// Directed bench for vc_sched: a FIFO occupancy model drives the empty flags, and a
// negedge monitor scores every push against the queue of expected VC ids.
module tb_vc_sched;
  import vc_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       empty_vchannel0, empty_vchannel1, empty_vchannel2, empty_vchannel3;
  logic       almost_full_out;
  logic [3:0] pop_vchannel;
  logic [1:0] sel_vchannel;
  logic       push_out;
  logic       idle;
  logic [7:0] grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;

  int         cnt [4];
  logic [3:0] emp_snap;
  logic [1:0] exp_q [$];
  int         n_tests = 0;
  int         n_fail = 0;

  // Valid/ready contract: a pop is issued after a clock edge, the FIFO consumes it before the
  // next edge, and push_out with sel_vchannel presents the popped VC one cycle later.

  always #5 clk = ~clk;

  vc_sched dut (
    .clk             (clk),
    .rst             (rst),
    .enb             (enb),
    .empty_vchannel0 (empty_vchannel0),
    .empty_vchannel1 (empty_vchannel1),
    .empty_vchannel2 (empty_vchannel2),
    .empty_vchannel3 (empty_vchannel3),
    .almost_full_out (almost_full_out),
    .pop_vchannel    (pop_vchannel),
    .sel_vchannel    (sel_vchannel),
    .push_out        (push_out),
    .idle            (idle),
    .grant_cnt0      (grant_cnt0),
    .grant_cnt1      (grant_cnt1),
    .grant_cnt2      (grant_cnt2),
    .grant_cnt3      (grant_cnt3)
  );

  assign empty_vchannel0 = (cnt[0] <= 0);
  assign empty_vchannel1 = (cnt[1] <= 0);
  assign empty_vchannel2 = (cnt[2] <= 0);
  assign empty_vchannel3 = (cnt[3] <= 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int id);
    logic [3:0] one;
    one = 4'b0001;
    return one << id;
  endfunction

  // FIFO model: empties as seen at the edge, pops consumed between edges.
  always @(posedge clk) emp_snap = {empty_vchannel3, empty_vchannel2, empty_vchannel1, empty_vchannel0};

  always @(negedge clk) begin
    if (pop_vchannel != 4'b0000) begin
      check("pop_onehot", $countones(pop_vchannel), 1);
      for (int i = 0; i < 4; i++) begin
        if (pop_vchannel[i]) begin
          check("pop_nonempty", {31'd0, emp_snap[i]}, 0);
          if (cnt[i] > 0) cnt[i]--;
        end
      end
    end
    if (push_out) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_push: got sel %0d expected no push", sel_vchannel);
      end else begin
        check("push_sel", {30'd0, sel_vchannel}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enb = 1'b1;
    almost_full_out = 1'b0;
    clear_fifos();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) step();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq2 [8];
    int seq3 [5];
    int k;
    seq2 = '{0, 0, 0, 1, 1, 2, 2, 3};
    seq3 = '{0, 1, 1, 1, 1};

    rst = 1'b1;
    enb = 1'b1;
    almost_full_out = 1'b0;
    clear_fifos();
    #12;
    check("rst_pop", pop_vchannel, 0);
    check("rst_push", push_out, 0);
    check("rst_sel", sel_vchannel, 0);
    check("rst_idle", idle, 1);
    check("rst_gcnt", {grant_cnt3, grant_cnt2, grant_cnt1, grant_cnt0}, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Sole VC2 with five entries: re-selected across credit reloads, no gaps.
    cnt[2] = 5;
    repeat (5) exp_q.push_back(2'b10);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_pop", pop_vchannel, 4'b0100);
      if (i == 0) check("t1_push_latency", push_out, 0);
    end
    step();
    check("t1_pop_end", pop_vchannel, 0);
    check("t1_idle", idle, 1);
    check("t1_last_push", push_out, 1);
    drain("t1_drain");

    // All VCs busy: weighted order 0,0,0,1,1,2,2,3 repeats with zero switch overhead.
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 1000;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) exp_q.push_back(seq2[i][1:0]);
    for (int i = 0; i < 16; i++) begin
      step();
      check("t2_pop", pop_vchannel, oh(seq2[i % 8]));
      if (i > 0) check("t2_no_gap", push_out, 1);
    end
    clear_fifos();
    step();
    check("t2_pop_end", pop_vchannel, 0);
    drain("t2_drain");

    // VC0 empties early, VC1 then re-selected as sole non-empty VC.
    do_reset();
    cnt[0] = 1;
    cnt[1] = 4;
    for (int i = 0; i < 5; i++) exp_q.push_back(seq3[i][1:0]);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_pop", pop_vchannel, oh(seq3[i]));
    end
    step();
    check("t3_pop_end", pop_vchannel, 0);
    check("t3_idle", idle, 1);
    drain("t3_drain");

    // Stall for three cycles with two pops still owed to VC0.
    do_reset();
    cnt[0] = 100;
    cnt[1] = 100;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    step();
    check("t4_first", pop_vchannel, 4'b0001);
    almost_full_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_stall_pop", pop_vchannel, 0);
      check("t4_stall_idle", idle, 0);
    end
    almost_full_out = 1'b0;
    step();
    check("t4_resume1", pop_vchannel, 4'b0001);
    step();
    check("t4_resume2", pop_vchannel, 4'b0001);
    step();
    check("t4_switch", pop_vchannel, 4'b0010);
    clear_fifos();
    step();
    check("t4_pop_end", pop_vchannel, 0);
    drain("t4_drain");

    // enb low freezes the scheduler but still completes the in-flight push.
    do_reset();
    cnt[1] = 3;
    repeat (3) exp_q.push_back(2'd1);
    step();
    check("t5_pop", pop_vchannel, 4'b0010);
    enb = 1'b0;
    step();
    check("t5_frozen_pop", pop_vchannel, 0);
    check("t5_frozen_push", push_out, 1);
    check("t5_frozen_sel", sel_vchannel, 1);
    step();
    check("t5_frozen_pop2", pop_vchannel, 0);
    check("t5_frozen_idle", idle, 0);
    enb = 1'b1;
    step();
    check("t5_resume1", pop_vchannel, 4'b0010);
    step();
    check("t5_resume2", pop_vchannel, 4'b0010);
    step();
    check("t5_pop_end", pop_vchannel, 0);
    check("t5_idle", idle, 1);
    drain("t5_drain");

    // Asynchronous reset while serving VC1; afterwards VC0 is searched first.
    do_reset();
    cnt[0] = 1;
    cnt[1] = 100;
    step();
    check("t6_pop0", pop_vchannel, 4'b0001);
    step();
    check("t6_pop1", pop_vchannel, 4'b0010);
    #1 rst = 1'b1;
    cnt[0] = 1;
    cnt[1] = 0;
    #1;
    check("t6_async_pop", pop_vchannel, 0);
    check("t6_async_push", push_out, 0);
    check("t6_async_idle", idle, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.push_back(2'd0);
    step();
    check("t6_first_grant", pop_vchannel, 4'b0001);
    step();
    check("t6_idle", idle, 1);
    drain("t6_drain");

    // 300 back-to-back pops on VC3 for the saturating grant counter.
    do_reset();
    cnt[3] = 300;
    repeat (300) exp_q.push_back(2'd3);
    k = 0;
    do begin
      step();
      k++;
    end while (!idle && k < 400);
    check("t7_cycles", k, 301);
`ifdef VC_SCHED_STATS_EN
    check("t7_gcnt3", grant_cnt3, 255);
`else
    check("t7_gcnt3", grant_cnt3, 0);
`endif
    check("t7_gcnt0", grant_cnt0, 0);
    drain("t7_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_sched.md
# vc_sched

Weighted round-robin scheduler for the four virtual-channel FIFOs feeding the shared output link. Each cycle it picks which VC FIFO to pop, drives a one-hot pop, and presents the selected VC id plus a push strobe to the downstream output FIFO one cycle later. It replaces free-running channel selection with a credit-based, backpressure-aware sequence and sits between the VC FIFOs and the output FIFO.

## Interface
- WEIGHT0, 3, pops granted to VC0 per turn (1..7)
- WEIGHT1, 2, pops per turn for VC1
- WEIGHT2, 2, pops per turn for VC2
- WEIGHT3, 1, pops per turn for VC3
- WEIGHT_W, 3, width of the credit counter

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- enb  in  1  global enable; 0 freezes all state, no pops
- empty_vchannel0..3  in  1 each  VCn FIFO empty; already reflects pops from the previous cycle
- almost_full_out  in  1  downstream output FIFO almost full
- pop_vchannel  out  4  one-hot pop to VC FIFOs, registered
- sel_vchannel  out  2  VC id of the data now on the FIFO read port (valid with push_out)
- push_out  out  1  push strobe to the output FIFO
- idle  out  1  high in IDLE state
- grant_cnt0..3  out  8 each  per-VC pop counters (see Configuration)

## Operation
- FSM states: IDLE, SERVE, STALL. Registers: cur_vc[1:0], credit[WEIGHT_W-1:0].
- IDLE: all VCs empty. On any non-empty VC, go to SERVE. cur_vc becomes the first non-empty VC searched from (cur_vc+1) mod 4. credit loads WEIGHTcur_vc. The pop is issued in the same cycle.
- SERVE: pop cur_vc and decrement credit. Move to the next VC when either condition holds:
  - credit reaches 0 after this pop, or
  - cur_vc goes empty.
  The next VC is the next non-empty one in round-robin order from cur_vc+1, and credit reloads from its weight. If the only non-empty VC is cur_vc, it is re-selected and credit reloads.
- Leftover credit is discarded on switch; there is no carry-over.
- Return to IDLE when all VCs are empty.
- STALL: entered from SERVE or IDLE whenever almost_full_out=1. No pops while in STALL. cur_vc and credit are held. On almost_full_out=0, return to SERVE (or IDLE if all VCs are empty).
- almost_full_out has priority over every other transition.
- enb=0: pop_vchannel forced 0. push_out is still generated for a pop issued in the previous cycle, so no data is lost. State is held.
- Never pop an empty VC. At most one pop bit set in any cycle.

## Timing
- Decision at edge k uses inputs sampled at k. pop_vchannel is valid after edge k.
- push_out and sel_vchannel are valid after edge k+1, one cycle of FIFO read latency.
- Back-to-back pops on the same VC are allowed every cycle.
- Switch overhead is zero: the last pop of VCa and the first pop of VCb are in consecutive cycles.
- almost_full_out sampled high at edge k: no pop after k. A pop issued at k-1 still pushes after k, so the output FIFO needs 1 entry of headroom at almost-full.
- Reset values: state IDLE, cur_vc=3 (so VC0 is searched first), credit=0, pop_vchannel=0, push_out=0, sel_vchannel=0, idle=1, grant_cnt*=0.
- Reset mid-operation clears the in-flight push pipeline. A pop already seen by a FIFO is lost by design.

## Configuration
- VC_SCHED_STATS_EN defined:
  - grant_cnt0..3 count pops per VC, 8-bit, saturating at 255.
  - Counters are cleared only by rst.
- Undefined: grant_cnt0..3 are tied to 0 and no counter logic is built.

## Structure
- vc_sched_pkg:
  - FSM state encoding (IDLE=2'b00, SERVE=2'b01, STALL=2'b10).
  - VC ids VCHANNEL0..3 = 2'b00..2'b11.
  - Default weights.
- Sub-module rr_next_vc: combinational next-non-empty search. Inputs are the 4-bit non-empty vector and start index; outputs are the next VC id and an any_valid flag.

## Test plan
- Only VC2 non-empty, 5 entries, weights default -> pop_vchannel=4'b0100 for 5 consecutive cycles. push_out follows 1 cycle later with sel_vchannel=2'b10. idle=1 after the 6th cycle.
- All VCs continuously non-empty -> repeating pop order 0,0,0,1,1,2,2,3 (8-cycle period), no gap cycles.
- VC0 has 1 entry, VC1 has 4 entries -> pop VC0 once, then VC1, VC1 (credit 2), VC1, VC1 (VC1 re-selected as sole non-empty).
- almost_full_out pulses high for 3 cycles mid-burst on VC0 with credit=2 -> no pops for 3 cycles, then VC0 popped 2 more times before switching.
- rst asserted asynchronously mid-SERVE -> pop_vchannel=0, push_out=0 immediately, idle=1. After release, the first grant goes to VC0.
- With VC_SCHED_STATS_EN: 300 pops on VC3 -> grant_cnt3=255. Without the macro, grant_cnt3 stays 0.
